// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage hazard controller.
// Decides every cycle what enters the ID/EX register. It turns the decoded
// control bundles into a bubble on load-use, branch-operand or HI/LO hazards.
// It drives the PC and IF/ID enables and the IF/ID flush, tracks a
// multi-cycle mul/div unit, and keeps a saturating stall-cycle counter.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-low reset
//   ID_WB/MEM/EX_Ctrl          decoded control bundles from the ID stage
//   ID_Rs/Rt, ID_UsesRs/Rt     source registers of the ID instruction
//   ID_Branch, ID_BranchTaken  branch resolved in ID and its outcome
//   ID_MulDivStart, ID_UsesHiLo  mul/div start and HI/LO dependence
//   EX_MemRead/RegWrite/DstReg   producer state in EX
//   MEM_MemRead/DstReg           load state in MEM
//   WB/MEM/EX_Ctrl_Out           bundles to ID/EX (zero on bubble)
//   PCWrite, IFIDWrite, IFIDFlush  front-end control
//   MulDivBusy                   registered mul/div busy flag
//   StallCount                   saturating count of stall cycles
module id_hazard_ctrl #(
  parameter int unsigned MULDIV_LAT = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  ID_WB_Ctrl,
  input  logic [4:0]  ID_MEM_Ctrl,
  input  logic [8:0]  ID_EX_Ctrl,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic        ID_MulDivStart,
  input  logic        ID_UsesHiLo,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_DstReg,
  input  logic        MEM_MemRead,
  input  logic [4:0]  MEM_DstReg,
  output logic [3:0]  WB_Ctrl_Out,
  output logic [4:0]  MEM_Ctrl_Out,
  output logic [8:0]  EX_Ctrl_Out,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        MulDivBusy,
  output logic [15:0] StallCount
);

  localparam logic [5:0] LatM1 = 6'(MULDIV_LAT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic        busy_q;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic load_use, br_ex, br_mem, hilo, stall, pass;
  logic rs_ex, rt_ex, rs_mem, rt_mem;

  // $zero never creates a dependence.
  function automatic logic hz(input logic uses, input logic [4:0] src, input logic [4:0] dst);
    return uses && (src != 5'd0) && (src == dst);
  endfunction

  always_comb begin
    rs_ex    = hz(ID_UsesRs, ID_Rs, EX_DstReg);
    rt_ex    = hz(ID_UsesRt, ID_Rt, EX_DstReg);
    rs_mem   = hz(ID_UsesRs, ID_Rs, MEM_DstReg);
    rt_mem   = hz(ID_UsesRt, ID_Rt, MEM_DstReg);
    load_use = EX_MemRead && (rs_ex || rt_ex);
    br_ex    = ID_Branch && EX_RegWrite && (rs_ex || rt_ex);
    br_mem   = ID_Branch && MEM_MemRead && (rs_mem || rt_mem);
    hilo     = ID_UsesHiLo && busy_q;
    stall    = load_use || br_ex || br_mem || hilo;
    // Reset low forces the same quiet outputs as a stall.
    pass     = Reset && !stall;
  end

  always_comb begin
    WB_Ctrl_Out  = pass ? ID_WB_Ctrl  : 4'd0;
    MEM_Ctrl_Out = pass ? ID_MEM_Ctrl : 5'd0;
    EX_Ctrl_Out  = pass ? ID_EX_Ctrl  : 9'd0;
    PCWrite      = pass;
    IFIDWrite    = pass;
    // A taken outcome seen during a stall is stale; it re-resolves later.
    IFIDFlush    = pass && ID_BranchTaken;
    MulDivBusy   = busy_q;
    StallCount   = stall_cnt_q;
  end

  // Mul/div occupancy: busy for exactly MULDIV_LAT cycles after an accepted start.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ID_MulDivStart && !stall) begin
            state_q <= StBusy;
            cnt_q   <= LatM1;
            busy_q  <= 1'b1;
          end
        end
        StBusy: begin
          if (cnt_q == 6'd0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

  logic        Clk;
  logic        Reset;
  logic [3:0]  ID_WB_Ctrl;
  logic [4:0]  ID_MEM_Ctrl;
  logic [8:0]  ID_EX_Ctrl;
  logic [4:0]  ID_Rs, ID_Rt;
  logic        ID_UsesRs, ID_UsesRt;
  logic        ID_Branch, ID_BranchTaken;
  logic        ID_MulDivStart, ID_UsesHiLo;
  logic        EX_MemRead, EX_RegWrite;
  logic [4:0]  EX_DstReg;
  logic        MEM_MemRead;
  logic [4:0]  MEM_DstReg;
  logic [3:0]  WB_Ctrl_Out;
  logic [4:0]  MEM_Ctrl_Out;
  logic [8:0]  EX_Ctrl_Out;
  logic        PCWrite, IFIDWrite, IFIDFlush, MulDivBusy;
  logic [15:0] StallCount;

  id_hazard_ctrl #(.MULDIV_LAT(4)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .ID_WB_Ctrl     (ID_WB_Ctrl),
    .ID_MEM_Ctrl    (ID_MEM_Ctrl),
    .ID_EX_Ctrl     (ID_EX_Ctrl),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRs      (ID_UsesRs),
    .ID_UsesRt      (ID_UsesRt),
    .ID_Branch      (ID_Branch),
    .ID_BranchTaken (ID_BranchTaken),
    .ID_MulDivStart (ID_MulDivStart),
    .ID_UsesHiLo    (ID_UsesHiLo),
    .EX_MemRead     (EX_MemRead),
    .EX_RegWrite    (EX_RegWrite),
    .EX_DstReg      (EX_DstReg),
    .MEM_MemRead    (MEM_MemRead),
    .MEM_DstReg     (MEM_DstReg),
    .WB_Ctrl_Out    (WB_Ctrl_Out),
    .MEM_Ctrl_Out   (MEM_Ctrl_Out),
    .EX_Ctrl_Out    (EX_Ctrl_Out),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IFIDFlush      (IFIDFlush),
    .MulDivBusy     (MulDivBusy),
    .StallCount     (StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        pcw;
    logic        flush;
    logic [3:0]  wb;
    logic [4:0]  mem;
    logic [8:0]  ex;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] model_cnt = 16'd0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stall counter reference: cleared by reset, saturating at FFFF.
  task automatic model_edge(input logic stalled);
    if (!Reset) model_cnt = 16'd0;
    else if (stalled && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
  endtask

  task automatic clr();
    ID_WB_Ctrl = 4'hA; ID_MEM_Ctrl = 5'h15; ID_EX_Ctrl = 9'h1A5;
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    ID_Branch = 1'b0; ID_BranchTaken = 1'b0;
    ID_MulDivStart = 1'b0; ID_UsesHiLo = 1'b0;
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_DstReg = 5'd0;
    MEM_MemRead = 1'b0; MEM_DstReg = 5'd0;
  endtask

  // One cycle: push expectation with current stimulus, compare mid-cycle, advance.
  task automatic step(input string tag, input logic exp_pass, input logic exp_busy);
    exp_t e;
    e.pcw   = exp_pass;
    e.flush = exp_pass & ID_BranchTaken;
    e.wb    = exp_pass ? ID_WB_Ctrl  : 4'd0;
    e.mem   = exp_pass ? ID_MEM_Ctrl : 5'd0;
    e.ex    = exp_pass ? ID_EX_Ctrl  : 9'd0;
    e.busy  = exp_busy;
    e.cnt   = model_cnt;
    sb.push_back(e);
    @(negedge Clk);
    if (sb.size() == 0) begin
      chk({tag, "/sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "/PCWrite"},   16'(PCWrite),      16'(e.pcw));
      chk({tag, "/IFIDWrite"}, 16'(IFIDWrite),    16'(e.pcw));
      chk({tag, "/IFIDFlush"}, 16'(IFIDFlush),    16'(e.flush));
      chk({tag, "/WB"},        16'(WB_Ctrl_Out),  16'(e.wb));
      chk({tag, "/MEM"},       16'(MEM_Ctrl_Out), 16'(e.mem));
      chk({tag, "/EX"},        16'(EX_Ctrl_Out),  16'(e.ex));
      chk({tag, "/Busy"},      16'(MulDivBusy),   16'(e.busy));
      chk({tag, "/StallCnt"},  StallCount,        e.cnt);
    end
    @(posedge Clk);
    model_edge(!exp_pass);
    #1;
  endtask

  initial begin
    clr();
    ID_BranchTaken = 1'b1;
    Reset = 1'b0;
    @(posedge Clk);
    model_edge(1'b0);
    #1;
    // Reset held: outputs forced quiet regardless of inputs.
    step("rst0", 1'b0, 1'b0);
    step("rst1", 1'b0, 1'b0);
    Reset = 1'b1;
    clr();
    step("idle", 1'b1, 1'b0);

    // Load-use on Rs, then the bubble sits in EX.
    EX_MemRead = 1'b1; EX_DstReg = 5'd2; ID_Rs = 5'd2; ID_UsesRs = 1'b1;
    step("lu_stall", 1'b0, 1'b0);
    EX_MemRead = 1'b0; EX_DstReg = 5'd0;
    step("lu_pass", 1'b1, 1'b0);

    // $zero never hazards.
    clr(); EX_MemRead = 1'b1; EX_DstReg = 5'd0; ID_Rs = 5'd0; ID_UsesRs = 1'b1;
    step("lu_zero", 1'b1, 1'b0);
    // Matching register but source unused.
    clr(); EX_MemRead = 1'b1; EX_DstReg = 5'd9; ID_Rs = 5'd9; ID_UsesRs = 1'b0;
    step("lu_unused", 1'b1, 1'b0);
    // Load-use via Rt.
    clr(); EX_MemRead = 1'b1; EX_DstReg = 5'd11; ID_Rt = 5'd11; ID_UsesRt = 1'b1;
    ID_EX_Ctrl = 9'h05A;
    step("lu_rt", 1'b0, 1'b0);

    // beq $3 after lw $3: two stalls, then taken branch flushes.
    clr(); ID_Branch = 1'b1; ID_BranchTaken = 1'b1;
    ID_Rs = 5'd3; ID_UsesRs = 1'b1; ID_Rt = 5'd4; ID_UsesRt = 1'b1;
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_DstReg = 5'd3;
    step("brld_1", 1'b0, 1'b0);
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_DstReg = 5'd0;
    MEM_MemRead = 1'b1; MEM_DstReg = 5'd3;
    step("brld_2", 1'b0, 1'b0);
    MEM_MemRead = 1'b0; MEM_DstReg = 5'd0;
    step("brld_go", 1'b1, 1'b0);

    // Branch after ALU producer: one stall, then clear.
    clr(); ID_Branch = 1'b1; ID_Rt = 5'd5; ID_UsesRt = 1'b1;
    EX_RegWrite = 1'b1; EX_DstReg = 5'd5;
    step("bralu_1", 1'b0, 1'b0);
    EX_RegWrite = 1'b0; EX_DstReg = 5'd0; MEM_DstReg = 5'd5;
    step("bralu_go", 1'b1, 1'b0);

    // A start that is itself stalled must not occupy the unit.
    clr(); ID_MulDivStart = 1'b1; ID_UsesHiLo = 1'b1;
    EX_MemRead = 1'b1; EX_DstReg = 5'd8; ID_Rs = 5'd8; ID_UsesRs = 1'b1;
    step("md_stallstart", 1'b0, 1'b0);
    clr();
    step("md_noissue", 1'b1, 1'b0);

    // mult accepted, mflo stalled for exactly 4 cycles.
    clr(); ID_MulDivStart = 1'b1; ID_UsesHiLo = 1'b1;
    step("md_start", 1'b1, 1'b0);
    clr(); ID_UsesHiLo = 1'b1; ID_EX_Ctrl = 9'h133;
    for (int i = 0; i < 4; i++) step($sformatf("mflo_b%0d", i), 1'b0, 1'b1);
    step("mflo_go", 1'b1, 1'b0);

    // Reset during BUSY aborts the operation.
    clr(); ID_MulDivStart = 1'b1; ID_UsesHiLo = 1'b1;
    step("md2_start", 1'b1, 1'b0);
    clr();
    step("md2_cnt3", 1'b1, 1'b1);
    Reset = 1'b0; ID_BranchTaken = 1'b1;
    step("md2_rst_a", 1'b0, 1'b1);
    step("md2_rst_b", 1'b0, 1'b0);
    Reset = 1'b1; clr(); ID_UsesHiLo = 1'b1;
    step("md2_after", 1'b1, 1'b0);

    // Counter saturation under a persistent load-use.
    clr(); EX_MemRead = 1'b1; EX_DstReg = 5'd7; ID_Rs = 5'd7; ID_UsesRs = 1'b1;
    while (model_cnt != 16'hFFFE) begin
      @(posedge Clk);
      model_edge(1'b1);
      #1;
    end
    step("sat_fffe", 1'b0, 1'b0);
    step("sat_ffff", 1'b0, 1'b0);
    repeat (4500) begin
      @(posedge Clk);
      model_edge(1'b1);
      #1;
    end
    step("sat_hold", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
